// File: rtl/cnn_pkg.sv
// Shared index and width helpers for the convolution window path.
// Window element (r, c) sits at bit offset win_idx(n, r, c) * bit_size.
package cnn_pkg;

  function automatic int win_idx(input int n, input int r, input int c);
    return r * n + c;
  endfunction

  function automatic int win_bits(input int n, input int bit_size);
    return bit_size * n * n;
  endfunction

  function automatic int cnt_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/window_gen_nxn_line_buffer.sv
// One image row of history: read-before-write at the shared column pointer.
// Contents are deliberately not reset; stale data never reaches a valid window.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int Width   = 28,
  parameter int BitSize = 2
) (
  input  logic                       clk,
  input  logic                       shift_en,
  input  logic [cnt_bits(Width)-1:0] ptr,
  input  logic [BitSize-1:0]         wr_data,
  output logic [BitSize-1:0]         rd_data
);

  logic [BitSize-1:0] mem_q [Width];

  assign rd_data = mem_q[ptr];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem_q[ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_gen_nxn.sv
// Raster-order pixel stream in, every valid NxN window out (stride 1, no padding).
// One output register; in_ready drops only while a presented window is stalled.
module window_gen_nxn
  import cnn_pkg::*;
#(
  parameter int N           = 3,
  parameter int BitSize     = 2,
  parameter int ImageWidth  = 28,
  parameter int ImageHeight = 28
) (
  input  logic                             clk,
  input  logic                             res_n,
  input  logic                             in_valid,
  input  logic [BitSize-1:0]               in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [win_bits(N, BitSize)-1:0]  out_data,
  output logic                             frame_done
);

  localparam int WinW = win_bits(N, BitSize);
  localparam int ColW = cnt_bits(ImageWidth);
  localparam int RowW = cnt_bits(ImageHeight);
  localparam logic [ColW-1:0] ColLast  = ColW'(ImageWidth - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(N - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(ImageHeight - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(N - 1);

  logic [ColW-1:0]    col_q, col_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [WinW-1:0]    win_q, win_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               accept;
  logic [BitSize-1:0] lb_rd   [N-1];
  logic [BitSize-1:0] lb_wr   [N-1];
  logic [BitSize-1:0] new_col [N];

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = win_q;
  assign frame_done = frame_done_q;

  // Buffer 0 holds the row just above the incoming pixel; higher buffers are older rows.
  for (genvar k = 0; k < N - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_wr[k] = in_data;
    end else begin : g_tail
      assign lb_wr[k] = lb_rd[k-1];
    end

    line_buffer #(
      .Width   (ImageWidth),
      .BitSize (BitSize)
    ) u_line_buffer (
      .clk      (clk),
      .shift_en (accept),
      .ptr      (col_q),
      .wr_data  (lb_wr[k]),
      .rd_data  (lb_rd[k])
    );

    assign new_col[N-2-k] = lb_rd[k];
  end
  assign new_col[N-1] = in_data;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_valid_d  = out_valid_q;
    frame_done_d = frame_done_q;
    if (accept) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N - 1; c++) begin
          win_d[win_idx(N, r, c)*BitSize +: BitSize] = win_q[win_idx(N, r, c + 1)*BitSize +: BitSize];
        end
        win_d[win_idx(N, r, N - 1)*BitSize +: BitSize] = new_col[r];
      end
      // Columns left over from the previous row are flushed by the col qualifier.
      out_valid_d  = (row_q >= RowFirst) && (col_q >= ColFirst);
      frame_done_d = out_valid_d && (row_q == RowLast) && (col_q == ColLast);
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_window_gen_nxn.sv
// Bench for window_gen_nxn: a 3x3/8-bit/4x4 instance and a 2x2/2-bit/5x3 instance,
// checked every cycle against an image-array reference plus literal window values.
module tb_window_gen_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res_n;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, frame_done_a;
  logic [7:0]  in_data_a;
  logic [71:0] out_data_a;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, frame_done_b;
  logic [1:0]  in_data_b;
  logic [7:0]  out_data_b;

  window_gen_nxn #(.N(3), .BitSize(8), .ImageWidth(4), .ImageHeight(4)) dut_a (
    .clk(clk), .res_n(res_n), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .frame_done(frame_done_a)
  );

  window_gen_nxn #(.N(2), .BitSize(2), .ImageWidth(5), .ImageHeight(3)) dut_b (
    .clk(clk), .res_n(res_n), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .frame_done(frame_done_b)
  );

  // Hand-computed windows of the 4x4 image with pixel = 4r+c (element 8 in the top byte).
  localparam logic [71:0] W0 = {8'd10, 8'd9,  8'd8,  8'd6,  8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] W1 = {8'd11, 8'd10, 8'd9,  8'd7,  8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
  localparam logic [71:0] W2 = {8'd14, 8'd13, 8'd12, 8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4};
  localparam logic [71:0] W3 = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
  // 5x3 image with pixel = (5r+c) mod 4: first and last 2x2 windows are both 0,1,1,2.
  localparam logic [7:0]  WB = 8'b10_01_01_00;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: remembers the accepted image and queues the windows it implies.
  int           img    [2][8][8];
  int           pr     [2];
  int           pc     [2];
  logic [72:0]  fifo   [2][8];
  int           f_head [2];
  int           f_cnt  [2];
  int           wins   [2];
  int           frames [2];

  logic        m_iv, m_ir, m_ov, m_ordy, m_fd;
  logic [71:0] m_od;
  int          m_din, m_n, m_bs, m_w, m_h;

  function automatic logic [71:0] model_win(input int ch, input int n, input int bs,
                                            input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < n; rr++) begin
      for (int cc = 0; cc < n; cc++) begin
        w = w | (72'(img[ch][r-n+1+rr][c-n+1+cc]) << ((rr * n + cc) * bs));
      end
    end
    return w;
  endfunction

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      pr[ch] = 0; pc[ch] = 0; f_head[ch] = 0; f_cnt[ch] = 0; wins[ch] = 0; frames[ch] = 0;
    end
  end

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (ch == 0) begin
        m_iv = in_valid_a; m_ir = in_ready_a; m_ov = out_valid_a; m_ordy = out_ready_a;
        m_fd = frame_done_a; m_od = out_data_a; m_din = int'(in_data_a);
        m_n = 3; m_bs = 8; m_w = 4; m_h = 4;
      end else begin
        m_iv = in_valid_b; m_ir = in_ready_b; m_ov = out_valid_b; m_ordy = out_ready_b;
        m_fd = frame_done_b; m_od = 72'(out_data_b); m_din = int'(in_data_b);
        m_n = 2; m_bs = 2; m_w = 5; m_h = 3;
      end
      if (!res_n) begin
        f_cnt[ch] = 0; pr[ch] = 0; pc[ch] = 0;
      end else begin
        chk($sformatf("ch%0d_out_valid", ch), 73'(m_ov), 73'(f_cnt[ch] != 0));
        chk($sformatf("ch%0d_in_ready", ch), 73'(m_ir), 73'(!m_ov || m_ordy));
        if (f_cnt[ch] != 0) begin
          chk($sformatf("ch%0d_window", ch), {m_fd, m_od}, fifo[ch][f_head[ch]]);
          if (m_ov && m_ordy) begin
            wins[ch]++;
            if (m_fd) frames[ch]++;
            f_head[ch] = (f_head[ch] + 1) % 8;
            f_cnt[ch]--;
          end
        end
        if (m_iv && m_ir) begin
          img[ch][pr[ch]][pc[ch]] = m_din;
          if (pr[ch] >= m_n - 1 && pc[ch] >= m_n - 1) begin
            fifo[ch][(f_head[ch] + f_cnt[ch]) % 8] =
              {1'(pr[ch] == m_h - 1 && pc[ch] == m_w - 1), model_win(ch, m_n, m_bs, pr[ch], pc[ch])};
            f_cnt[ch]++;
          end
          if (pc[ch] == m_w - 1) begin
            pc[ch] = 0;
            pr[ch] = (pr[ch] == m_h - 1) ? 0 : pr[ch] + 1;
          end else begin
            pc[ch]++;
          end
        end
      end
    end
  end

  // Present one pixel and return #1 after the edge that accepts it.
  task automatic feed_a(input int v);
    in_valid_a = 1'b1;
    in_data_a  = 8'(v);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready_a) break;
    end
    chk("feed_a_ready", 73'(in_ready_a), 73'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic feed_b(input int v);
    in_valid_b = 1'b1;
    in_data_b  = 2'(v);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready_b) break;
    end
    chk("feed_b_ready", 73'(in_ready_b), 73'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    in_valid_a = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0, f0;
    res_n = 1'b0;
    in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    res_n = 1'b1;
    chk("rst_a_valid", 73'(out_valid_a), 73'(0));
    chk("rst_a_done",  73'(frame_done_a), 73'(0));
    chk("rst_a_data",  73'(out_data_a), 73'(0));
    chk("rst_b_valid", 73'(out_valid_b), 73'(0));
    chk("rst_b_data",  73'(out_data_b), 73'(0));

    // Continuous flow, one frame.
    w0 = wins[0]; f0 = frames[0];
    for (int p = 0; p < 16; p++) begin
      feed_a(p);
      chk("t1_in_ready", 73'(in_ready_a), 73'(1));
      if (p == 9)  chk("t1_no_valid_before_10", 73'(out_valid_a), 73'(0));
      if (p == 10) begin
        chk("t1_first_valid", 73'(out_valid_a), 73'(1));
        chk("t1_first_window", 73'(out_data_a), 73'(W0));
      end
      if (p == 15) begin
        chk("t1_last_window", 73'(out_data_a), 73'(W3));
        chk("t1_last_done", 73'(frame_done_a), 73'(1));
      end
    end
    idle_a();
    chk("t1_valid_clears", 73'(out_valid_a), 73'(0));
    chk("t1_done_clears", 73'(frame_done_a), 73'(0));
    chk("t1_window_count", 73'(wins[0] - w0), 73'(4));
    chk("t1_frame_count", 73'(frames[0] - f0), 73'(1));

    // Stall the second window for three cycles.
    w0 = wins[0];
    for (int p = 0; p < 12; p++) feed_a(p);
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_valid", 73'(out_valid_a), 73'(1));
      chk("t2_hold_data", 73'(out_data_a), 73'(W1));
      chk("t2_hold_done", 73'(frame_done_a), 73'(0));
      chk("t2_hold_in_ready", 73'(in_ready_a), 73'(0));
    end
    @(posedge clk);
    #1;
    out_ready_a = 1'b1;
    for (int p = 12; p < 16; p++) begin
      feed_a(p);
      if (p == 14) chk("t2_after_release", 73'(out_data_a), 73'(W2));
      if (p == 15) chk("t2_last_done", 73'(frame_done_a), 73'(1));
    end
    idle_a();
    chk("t2_window_count", 73'(wins[0] - w0), 73'(4));

    // Three back-to-back frames with random input gaps.
    w0 = wins[0]; f0 = frames[0];
    for (int fr = 0; fr < 3; fr++) begin
      for (int p = 0; p < 16; p++) begin
        if ($urandom_range(1, 0) == 1) idle_a();
        feed_a(p);
      end
    end
    idle_a();
    idle_a();
    chk("t3_window_count", 73'(wins[0] - w0), 73'(12));
    chk("t3_frame_count", 73'(frames[0] - f0), 73'(3));

    // Reset after seven pixels of a frame.
    for (int p = 0; p < 7; p++) feed_a(p);
    in_valid_a = 1'b0;
    res_n = 1'b0;
    @(posedge clk);
    #1;
    res_n = 1'b1;
    chk("t4_valid_after_rst", 73'(out_valid_a), 73'(0));
    chk("t4_done_after_rst", 73'(frame_done_a), 73'(0));

    // Reset while a stalled window is pending drops it.
    for (int p = 0; p < 11; p++) feed_a(p);
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_pending_valid", 73'(out_valid_a), 73'(1));
    res_n = 1'b0;
    @(posedge clk);
    #1;
    res_n = 1'b1;
    out_ready_a = 1'b1;
    chk("t4_pending_dropped", 73'(out_valid_a), 73'(0));
    chk("t4_window_regs_cleared", 73'(out_data_a), 73'(0));

    w0 = wins[0];
    for (int p = 0; p < 16; p++) begin
      feed_a(p);
      if (p == 10) chk("t4_first_window", 73'(out_data_a), 73'(W0));
      if (p == 15) chk("t4_last_window", 73'({frame_done_a, out_data_a}), {1'b1, W3});
    end
    idle_a();
    chk("t4_window_count", 73'(wins[0] - w0), 73'(4));

    // Small 2x2 instance over a 5x3 frame.
    w0 = wins[1]; f0 = frames[1];
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        feed_b((5 * r + c) % 4);
        if (r == 1 && c == 1) chk("t5_first_window", 73'({out_valid_b, out_data_b}), 73'({1'b1, WB}));
        if (r == 2 && c == 4) chk("t5_last_window", 73'({frame_done_b, out_data_b}), 73'({1'b1, WB}));
      end
    end
    in_valid_b = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_window_count", 73'(wins[1] - w0), 73'(8));
    chk("t5_frame_count", 73'(frames[1] - f0), 73'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
